word_narrow_tx: RTL

Transmit-side narrower for the 16-bit datapath: accepts 16-bit words under a valid/ready handshake and emits them on an 8-bit byte stream. A word whose high byte is the pure sign or zero extension of its low byte (per `in_sign`) goes out as a one-byte frame. Every other word goes out as a two-byte frame. The receiving end rebuilds the word by extending one-byte frames with the frame's `out_sign`. The block sits between the core's 16-bit result path and any byte-wide link or memory port.

---
 rtl/word_narrow_tx_pkg.sv | 14 +
 rtl/byte_fit_chk.sv | 21 ++
 rtl/word_narrow_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/word_narrow_tx_pkg.sv
// Shared widths and FSM encoding for the 16-to-8 transmit narrower.
package wisc_narrow_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

endpackage

// File: rtl/byte_fit_chk.sv
// Decides whether a 16-bit word survives a round trip through one byte plus
// sign/zero extension, i.e. the exact inverse of the 8-to-16 extender.
module byte_fit_chk
  import wisc_narrow_pkg::*;
(
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_sign,
  output logic              fit
);

  logic signed [BYTE_W-1:0] lo_s;
  logic        [BYTE_W-1:0] ext_hi;

  // The high byte must equal what the extender would regenerate from the low byte.
  always_comb begin
    lo_s   = signed'(in_data[BYTE_W-1:0]);
    ext_hi = in_sign ? {BYTE_W{lo_s[BYTE_W-1]}} : '0;
    fit    = (in_data[WORD_W-1:BYTE_W] == ext_hi);
  end

endmodule

// File: rtl/word_narrow_tx.sv
// Transmit-side narrower: emits each accepted 16-bit word as a one-byte frame
// when it fits the extension rule, otherwise as a two-byte frame (low first).
module word_narrow_tx
  import wisc_narrow_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_first,
  output logic              out_last,
  output logic              out_sign,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  short_cnt,
  output logic [CNT_W-1:0]  long_cnt
);

  state_t              state_q;
  state_t              state_d;
  logic                in_fit;
  logic [WORD_W-1:0]   hold_data_p0;
  logic                hold_fit_p0;
  logic                hold_sign_p0;
  logic                frame_done;
  logic                accept;

  byte_fit_chk u_fit (
    .in_data (in_data),
    .in_sign (in_sign),
    .fit     (in_fit)
  );

  // Handshake: a new word is taken when idle or on the edge the current frame finishes.
  always_comb begin
    frame_done = out_ready && (((state_q == SEND_LO) && hold_fit_p0) || (state_q == SEND_HI));
    in_ready   = rst_n && ((state_q == EMPTY) || frame_done);
    accept     = in_valid && in_ready;
  end

  // ---- stage p0: hold register (word payload needs no reset; state gates its use) ----
  // Capture the payload of each accepted word.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_p0 <= in_data;
    end
  end

  // Capture the frame-shape controls of each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_fit_p0  <= 1'b0;
      hold_sign_p0 <= 1'b0;
    end else if (accept) begin
      hold_fit_p0  <= in_fit;
      hold_sign_p0 <= in_sign;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and byte-stream outputs; outputs depend only on held state so they stay stable under stall.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_byte  = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_sign  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = SEND_LO;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_byte  = hold_data_p0[BYTE_W-1:0];
        out_first = 1'b1;
        out_last  = hold_fit_p0;
        out_sign  = hold_sign_p0;
        if (out_ready) begin
          if (hold_fit_p0) state_d = accept ? SEND_LO : EMPTY;
          else             state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_byte  = hold_data_p0[WORD_W-1:BYTE_W];
        out_last  = 1'b1;
        out_sign  = hold_sign_p0;
        if (out_ready) state_d = accept ? SEND_LO : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Frame counters; a clear wins over a same-cycle completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_cnt <= '0;
      long_cnt  <= '0;
    end else if (clr_cnt) begin
      short_cnt <= '0;
      long_cnt  <= '0;
    end else if (frame_done) begin
      if (state_q == SEND_LO) short_cnt <= short_cnt + CNT_W'(1);
      else                    long_cnt  <= long_cnt + CNT_W'(1);
    end
  end

endmodule
